// File: rtl/results_conv_writer_if.sv
// Source-side handshake and results_conv write-bus signals of the frame writer.
// The writer uses the master view. A driver or monitor on the other side uses the slave view.
interface results_conv_writer_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          zero_req;
    logic [AW-1:0] address;
    logic [DW-1:0] din;
    logic          din_oe;
    logic          rcc_clk;
    logic          busy;
    logic          frame_done;

    modport master (
        input  in_valid, in_data, zero_req,
        output in_ready, address, din, din_oe, rcc_clk, busy, frame_done
    );

    modport slave (
        output in_valid, in_data, zero_req,
        input  in_ready, address, din, din_oe, rcc_clk, busy, frame_done
    );
endinterface

// File: rtl/results_conv_writer.sv
// Buffers one NWORDS-word result frame and replays it onto the results_conv
// address/din/rcc_clk strobe bus. The bus timing is fixed: setup, strobe, release, then an inter-frame gap.
module results_conv_writer #(
    parameter int DW      = 16,
    parameter int AW      = 4,
    parameter int NWORDS  = 9,
    parameter int PRE_CYC = 4,
    parameter int GAP_CYC = 160
) (
    input  logic                  clk,
    input  logic                  reset,
    results_conv_writer_if.master bus
);
    localparam int CW   = $clog2(NWORDS + 1);
    localparam int TMAX = (PRE_CYC > GAP_CYC) ? PRE_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PRE     = 3'd2,
        SETUP   = 3'd3,
        STRB_HI = 3'd4,
        STRB_LO = 3'd5,
        RELEASE = 3'd6,
        GAP     = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          zero_q, zero_d;
    logic [DW-1:0] wbuf_q [NWORDS];
    logic [DW-1:0] wbuf_d [NWORDS];
    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] din_q, din_d;
    logic          din_oe_q, din_oe_d;
    logic          rcc_clk_q, rcc_clk_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          in_ready_q, in_ready_d;

    logic          take_zero_s;
    logic          take_word_s;
    logic [CW-1:0] cnt_nxt_s;

    // zero_req outranks a simultaneous word, and only an empty buffer may start a blank frame
    assign take_zero_s = in_ready_q & bus.zero_req & (state_q == IDLE) & (cnt_q == {CW{1'b0}});
    assign take_word_s = in_ready_q & bus.in_valid & ~take_zero_s
                       & ((state_q == IDLE) | (state_q == LOAD));
    assign cnt_nxt_s   = cnt_q + CW'(1);

    // Next-state, buffer and bus output computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmr_d        = tmr_q;
        zero_d       = zero_q;
        wbuf_d       = wbuf_q;
        address_d    = address_q;
        din_d        = din_q;
        din_oe_d     = din_oe_q;
        rcc_clk_d    = rcc_clk_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        in_ready_d   = in_ready_q;
        case (state_q)
            IDLE, LOAD: begin
                in_ready_d = 1'b1;
                if (take_zero_s) begin
                    state_d    = PRE;
                    zero_d     = 1'b1;
                    cnt_d      = {CW{1'b0}};
                    tmr_d      = {TW{1'b0}};
                    in_ready_d = 1'b0;
                end else if (take_word_s) begin
                    wbuf_d[cnt_q] = bus.in_data;
                    if (cnt_q == CW'(NWORDS - 1)) begin
                        state_d    = PRE;
                        zero_d     = 1'b0;
                        cnt_d      = {CW{1'b0}};
                        tmr_d      = {TW{1'b0}};
                        in_ready_d = 1'b0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = cnt_nxt_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            PRE: begin
                busy_d = 1'b1;
                if (tmr_q == TW'(PRE_CYC - 1)) begin
                    state_d   = SETUP;
                    address_d = AW'(cnt_q);
                    din_d     = zero_q ? {DW{1'b0}} : wbuf_q[cnt_q];
                    din_oe_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            SETUP: begin
                state_d   = STRB_HI;
                rcc_clk_d = 1'b1;
            end
            STRB_HI: begin
                state_d   = STRB_LO;
                rcc_clk_d = 1'b0;
            end
            STRB_LO: begin
                state_d  = RELEASE;
                din_oe_d = 1'b0;
            end
            RELEASE: begin
                if (cnt_q == CW'(NWORDS - 1)) begin
                    state_d      = GAP;
                    cnt_d        = {CW{1'b0}};
                    tmr_d        = {TW{1'b0}};
                    frame_done_d = 1'b1;
                end else begin
                    state_d   = SETUP;
                    cnt_d     = cnt_nxt_s;
                    address_d = AW'(cnt_nxt_s);
                    din_d     = zero_q ? {DW{1'b0}} : wbuf_q[cnt_nxt_s];
                    din_oe_d  = 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == TW'(GAP_CYC - 1)) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    address_d  = {AW{1'b0}};
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = {CW{1'b0}};
                din_oe_d   = 1'b0;
                rcc_clk_d  = 1'b0;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State, buffer and registered bus outputs; reset drops the strobe and drive enable at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= {CW{1'b0}};
            tmr_q        <= {TW{1'b0}};
            zero_q       <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                wbuf_q[i] <= {DW{1'b0}};
            end
            address_q    <= {AW{1'b0}};
            din_q        <= {DW{1'b0}};
            din_oe_q     <= 1'b0;
            rcc_clk_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmr_q        <= tmr_d;
            zero_q       <= zero_d;
            wbuf_q       <= wbuf_d;
            address_q    <= address_d;
            din_q        <= din_d;
            din_oe_q     <= din_oe_d;
            rcc_clk_q    <= rcc_clk_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.address    = address_q;
    assign bus.din        = din_q;
    assign bus.din_oe     = din_oe_q;
    assign bus.rcc_clk    = rcc_clk_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_results_conv_writer.sv
// Directed bench for results_conv_writer. It loads frames, checks every output cycle by cycle against a
// timing model keyed to the last-accept edge, and covers blank frames and reset mid-frame.
module tb_results_conv_writer;
    localparam int PRE = 4;
    localparam int NW  = 9;
    localparam int GAP = 160;
    localparam int T_DONE = PRE + 4 * NW;
    localparam int T_IDLE = T_DONE + GAP;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_bad;
    logic [15:0] w [NW];
    logic [15:0] last_din;

    results_conv_writer_if bus_if ();

    results_conv_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {7'd0, bus_if.address, bus_if.din, bus_if.din_oe, bus_if.rcc_clk,
                bus_if.busy, bus_if.frame_done, bus_if.in_ready};
    endfunction

    // Expected output vector t cycles after the last-accept edge
    function automatic logic [31:0] exp_vec(input int t, input logic z, input logic [15:0] last);
        logic [3:0]  a;
        logic [15:0] d;
        logic        oe, rc, bz, fd, rdy;
        int          k, ph;
        a   = 4'd0;
        d   = last;
        oe  = 1'b0;
        rc  = 1'b0;
        bz  = (t >= 1) && (t < T_IDLE);
        fd  = (t == T_DONE);
        rdy = (t >= T_IDLE);
        if (t >= PRE && t < T_DONE) begin
            k  = (t - PRE) / 4;
            ph = (t - PRE) % 4;
            a  = 4'(k);
            d  = z ? 16'h0000 : w[k];
            oe = (ph < 3);
            rc = (ph == 1);
        end else if (t >= T_DONE) begin
            a = (t < T_IDLE) ? 4'd8 : 4'd0;
            d = z ? 16'h0000 : w[NW-1];
        end else begin
            d = last;
        end
        return {7'd0, a, d, oe, rc, bz, fd, rdy};
    endfunction

    // Present a word or zero request and return at the negedge after the accepting edge
    task automatic accept(input logic z, input logic v, input logic [15:0] d);
        bit done;
        done = 1'b0;
        bus_if.zero_req = z;
        bus_if.in_valid = v;
        bus_if.in_data  = d;
        for (int n = 0; n < 400 && !done; n++) begin
            if (bus_if.in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus_if.zero_req = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("accept_in_time", 32'(done), 32'd1);
    endtask

    task automatic load_frame(input int mode);
        for (int i = 0; i < NW; i++) begin
            if (mode == 1 && (i == 2 || i == 6)) repeat (10) @(negedge clk);
            accept(1'b0, 1'b1, w[i]);
            if (mode == 2 && i == 1) begin
                bus_if.zero_req = 1'b1;
                @(negedge clk);
                bus_if.zero_req = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input logic z, input logic hold, input logic abort);
        int pulses;
        pulses = 0;
        if (hold) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = 16'hDEAD;
        end
        for (int t = 1; t <= T_IDLE; t++) begin
            @(negedge clk);
            chk($sformatf("t%0d", t), obs(), exp_vec(t, z, last_din));
            if (bus_if.rcc_clk) pulses++;
            if (abort && t == PRE + 4 * 4 + 1) begin
                #2 reset = 1'b1;
                #1 chk("reset_async", {29'd0, bus_if.rcc_clk, bus_if.din_oe, bus_if.in_ready}, 32'd0);
                @(negedge clk);
                chk("reset_hold", obs(), 32'd0);
                @(negedge clk);
                reset    = 1'b0;
                last_din = 16'h0000;
                return;
            end
        end
        bus_if.in_valid = 1'b0;
        chk("pulses", 32'(pulses), 32'(NW));
        last_din = z ? 16'h0000 : w[NW-1];
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 16'h0000;
        bus_if.zero_req = 1'b0;
        last_din = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_state", obs(), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NW; i++) w[i] = 16'(i + 1);
        load_frame(0);
        run_frame(1'b0, 1'b0, 1'b0);

        accept(1'b1, 1'b0, 16'h0000);
        run_frame(1'b1, 1'b0, 1'b0);

        accept(1'b1, 1'b1, 16'hBEEF);
        run_frame(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NW; i++) w[i] = 16'h1100 + 16'(i);
        load_frame(0);
        run_frame(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NW; i++) w[i] = 16'hA5A0 ^ 16'(i * 16'h0111);
        load_frame(2);
        run_frame(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NW; i++) w[i] = 16'h8000 | 16'(i * 3);
        load_frame(0);
        run_frame(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < NW; i++) w[i] = 16'h0F00 + 16'(i);
        load_frame(0);
        run_frame(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NW; i++) w[i] = 16'h5500 + 16'(i);
        load_frame(0);
        run_frame(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NW; i++) w[i] = 16'h7700 + 16'(i);
        load_frame(0);
        run_frame(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NW; i++) w[i] = 16'hC000 + 16'(i * 7);
        load_frame(1);
        run_frame(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
